// File: rtl/finv.sv
// finv : combinational binary32 reciprocal y = 1/x, truncated mantissa.
// ovf flags a zero/denormal input; reciprocals below the normal range flush to zero.
`default_nettype none

module finv (
  input  logic [31:0] x,
  output logic [31:0] y,
  output logic        ovf
);

  logic [47:0] w_quo;
  logic [8:0]  w_er;
  logic        w_m_zero;
  logic        w_unused;

  assign w_m_zero = (x[22:0] == 23'd0);
  // 2^47 / 1.m (scaled) lies in [2^23, 2^24) for m != 0, giving the mantissa directly.
  assign w_quo    = 48'h8000_0000_0000 / {24'd0, 1'b1, x[22:0]};
  assign w_er     = (w_m_zero ? 9'd254 : 9'd253) - {1'b0, x[30:23]};
  assign w_unused = ^w_quo[47:23];

  always_comb begin
    y   = {x[31], w_er[7:0], (w_m_zero ? 23'd0 : w_quo[22:0])};
    ovf = 1'b0;
    if (x[30:23] == 8'd0) begin
      y   = {x[31], 8'hFF, 23'd0};
      ovf = 1'b1;
    end else if (w_er[8] || (w_er == 9'd0)) begin
      y   = {x[31], 31'd0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fdiv_pipe.sv
// fdiv_pipe : 3-stage pipelined binary32 divider, q = x1 * finv(x2).
// Valid/ready on both sides; all stages stall together on output backpressure.
`default_nettype none

module fdiv_pipe #(
  parameter int BIAS = 127
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic        ovf
);

  logic        w_adv;
  logic [31:0] w_r;
  logic        w_fovf;

  logic        r_v1, r_v2, r_v3;
  logic [31:0] r_x1, r_r;
  logic        r_fovf1, r_z1_1, r_z2_1;

  logic               r_s2, r_fovf2, r_z1_2, r_z2_2;
  logic signed [9:0]  r_e2;
  logic [47:0]        r_p2;

  logic [31:0] r_q3;
  logic        r_ovf3;

  logic signed [9:0] w_e2, w_e_n, w_e_f;
  logic [47:0]       w_p2;
  logic [22:0]       w_mant_raw;
  logic              w_guard;
  logic [23:0]       w_rnd;
  logic [31:0]       w_q3;
  logic              w_ovf3;
  logic              w_unused;

  finv u_finv (
    .x   (x2),
    .y   (w_r),
    .ovf (w_fovf)
  );

  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  // Gate outputs so stale datapath contents never show while idle.
  assign q         = r_v3 ? r_q3 : 32'd0;
  assign ovf       = r_v3 & r_ovf3;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  assign w_e2 = $signed({2'b00, r_x1[30:23]} + {2'b00, r_r[30:23]} - 10'(BIAS));
  assign w_p2 = 48'({1'b1, r_x1[22:0]}) * 48'({1'b1, r_r[22:0]});

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_x1    <= x1;
      r_r     <= w_r;
      r_fovf1 <= w_fovf;
      r_z1_1  <= (x1[30:23] == 8'd0);
      r_z2_1  <= (x2[30:23] == 8'd0);

      r_s2    <= r_x1[31] ^ r_r[31];
      r_e2    <= w_e2;
      r_p2    <= w_p2;
      r_fovf2 <= r_fovf1;
      r_z1_2  <= r_z1_1;
      r_z2_2  <= r_z2_1;

      r_q3    <= w_q3;
      r_ovf3  <= w_ovf3;
    end
  end

  assign w_e_n      = r_p2[47] ? (r_e2 + 10'sd1) : r_e2;
  assign w_mant_raw = r_p2[47] ? r_p2[46:24] : r_p2[45:23];
  assign w_guard    = r_p2[47] ? r_p2[23] : r_p2[22];
  // Carry out of the rounding add leaves the low 23 bits at zero.
  assign w_rnd      = {1'b0, w_mant_raw} + {23'd0, w_guard};
  assign w_e_f      = w_e_n + (w_rnd[23] ? 10'sd1 : 10'sd0);
  assign w_unused   = ^r_p2[21:0];

  always_comb begin
    w_q3   = {r_s2, w_e_f[7:0], w_rnd[22:0]};
    w_ovf3 = 1'b0;
    if (r_z2_2) begin
      w_q3   = {r_s2, 8'hFF, 23'd0};
      w_ovf3 = 1'b1;
    end else if (r_z1_2) begin
      w_q3   = {r_s2, 31'd0};
    end else if (r_fovf2 || (w_e_f >= 10'sd255)) begin
      w_q3   = {r_s2, 8'hFF, 23'd0};
      w_ovf3 = 1'b1;
    end else if (w_e_f <= 10'sd0) begin
      w_q3   = {r_s2, 31'd0};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fdiv_pipe.sv
// tb_fdiv_pipe : scoreboard bench for fdiv_pipe (directed, random, stall, reset flush).
`default_nettype none

module tb_fdiv_pipe;

  typedef struct {
    logic [31:0] q;
    logic        ovf;
    int          tol;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x1, x2, q;
  logic        ovf;

  exp_t sb[$];
  exp_t cur;
  exp_t pop_e;
  bit   acc_done;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_out  = 0;

  fdiv_pipe #(.BIAS(127)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
    int d;
    logic bad;
    n_chk++;
    if (tol == 0) begin
      bad = (obs !== exp);
    end else begin
      d = int'(obs[30:0]) - int'(exp[30:0]);
      if (d < 0) d = -d;
      bad = (obs[31] !== exp[31]) || (d > tol);
    end
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (tol %0d ulp)", tag, obs, exp, tol);
    end
  endtask

  function automatic real f2r(input logic [31:0] a);
    real m, v;
    m = 1.0 + real'(a[22:0]) / 8388608.0;
    v = m * (2.0 ** real'(int'(a[30:23]) - 127));
    return a[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic s;
    real  a;
    int   e, m;
    logic [31:0] mb;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    if (a == 0.0) return {s, 31'd0};
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = int'((a - 1.0) * 8388608.0);
    if (m == 8388608) begin m = 0; e++; end
    mb = 32'(m);
    return {s, 8'(e + 127), mb[22:0]};
  endfunction

  // Scoreboard: push on accept, pop/compare on output transfer, mid-cycle sampling.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("spurious_out", {31'd0, out_valid}, 32'd0, 0);
          end else begin
            pop_e = sb.pop_front();
            check("q", q, pop_e.q, pop_e.tol);
            check("ovf", {31'd0, ovf}, {31'd0, pop_e.ovf}, 0);
            n_out++;
          end
        end else if (out_valid && sb.size() > 0) begin
          check("stall_q", q, sb[0].q, sb[0].tol);
        end
        if (in_valid && in_ready) begin
          sb.push_back(cur);
          acc_done = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic eovf, input int tol);
    int g;
    g        = 0;
    x1       = a;
    x2       = b;
    cur.q    = eq;
    cur.ovf  = eovf;
    cur.tol  = tol;
    acc_done = 1'b0;
    in_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      g++;
    end while (!acc_done && g < 100);
    if (!acc_done) check("accept_timeout", {31'd0, acc_done}, 32'd1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0, 0);
  endtask

  task automatic timed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq);
    send(a, b, eq, 1'b0, 0);
    check("lat_e1", {31'd0, out_valid}, 32'd0, 0);
    @(posedge clk); #1;
    check("lat_e2", {31'd0, out_valid}, 32'd0, 0);
    @(posedge clk); #1;
    check("lat_e3", {31'd0, out_valid}, 32'd1, 0);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rnd;
    int e1, e2, lo, hi, base;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x1        = 32'd0;
    x2        = 32'd0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0, 0);
    check("rst_q", q, 32'd0, 0);
    check("rst_ovf", {31'd0, ovf}, 32'd0, 0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1, 0);

    timed(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000);

    send(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 1'b0, 2);
    send(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b1, 0);
    send(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 0);
    send(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 0);
    send(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 0);
    drain();

    for (int i = 0; i < 24; i++) begin
      e1  = $urandom_range(254, 1);
      lo  = (e1 - 124 > 1) ? e1 - 124 : 1;
      hi  = (e1 + 122 < 252) ? e1 + 122 : 252;
      e2  = $urandom_range(hi, lo);
      rnd = $urandom();
      ra  = {rnd[31], 8'(e1), rnd[22:0]};
      rnd = $urandom();
      rb  = {rnd[31], 8'(e2), rnd[22:0]};
      send(ra, rb, r2f(f2r(ra) / f2r(rb)), 1'b0, 2);
    end
    drain();

    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = {1'b0, 8'(120 + i), 23'(i * 77777)};
          send(ra, 32'h4000_0000, ra - 32'h0080_0000, 1'b0, 0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(posedge clk); #1;
        check("bp_in_ready", {31'd0, in_ready}, 32'd0, 0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1, 0);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(n_out - base), 32'd8, 0);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0, 0);
    check("flush_q", q, 32'd0, 0);
    out_ready = 1'b1;
    base = n_out;
    repeat (6) @(posedge clk);
    #1 check("flush_none", 32'(n_out - base), 32'd0, 0);
    timed(32'h4100_0000, 32'h4080_0000, 32'h4000_0000);
    check("post_flush_count", 32'(n_out - base), 32'd1, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
